mshr_mem_issuer: RTL and testbench
==================================

Name: mshr_mem_issuer

Overview:
- Memory-side consumer of the cache MSHR.
- Drains pending MSHR entries through the read_next/rn_* interface and issues them as tagged memory requests.
- Accepts tagged (possibly out-of-order) memory responses and looks up the originating entry via get/get_tag.
- Returns line fills to the cache controller, then retires the entry via del/del_tag.

Parameters:
- addr_bits, 20, address width.
- data_bits, 90, line data width.
- mshr_tag_bits, 3, MSHR tag width.
- cpu_id_bits, 2, requester id width.
- ASSOC_BITS, 2, victim way width.
- MAX_OUTSTANDING, 4, maximum memory requests in flight (1..2**mshr_tag_bits).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-low reset.
- enable  in  1  global stall; when 0, all state holds and all pulse outputs are 0.
- rn_valid  in  1  MSHR has an unread entry.
- rn_addr / rn_data / rn_rw / rn_dirty / rn_cpu_id / rn_mshr_id  in  addr_bits / data_bits / 1 / 1 / cpu_id_bits / mshr_tag_bits  head entry fields.
- read_next  out  1  one-cycle pulse; advances the MSHR read pointer.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  addr_bits  request address.
- mem_req_data  out  data_bits  request data.
- mem_req_rw  out  1  1 = write, 0 = read.
- mem_req_tag  out  mshr_tag_bits  request tag.
- mem_resp_valid  in  1  response valid.
- mem_resp_ready  out  1  response accepted.
- mem_resp_tag  in  mshr_tag_bits  response tag.
- mem_resp_data  in  data_bits  response data.
- get  out  1  lookup strobe.
- get_tag  out  mshr_tag_bits  lookup tag.
- get_valid / get_addr / get_rw / get_dirty / get_cpu_id / get_victim  in  1 / addr_bits / 1 / 1 / cpu_id_bits / ASSOC_BITS  lookup result.
- fill_valid  out  1  fill to the cache.
- fill_ready  in  1  cache accepts the fill.
- fill_addr / fill_data / fill_dirty / fill_cpu_id / fill_victim  out  addr_bits / data_bits / 1 / cpu_id_bits / ASSOC_BITS  fill fields.
- del  out  1  retire pulse.
- del_tag  out  mshr_tag_bits  tag to retire.
- outstanding  out  mshr_tag_bits+1  requests in flight.
- resp_err  out  1  sticky: a response matched an invalid MSHR entry.

Behaviour:
- Reset (reset=0 at a rising edge): both FSMs return to IDLE and outstanding is cleared. resp_err, all valid outputs and all pulse outputs go to 0. All data, address and tag registers go to 0. Any in-flight request or fill is abandoned.
- Issue FSM, I_IDLE → I_REQ:
  - Transition when rn_valid=1 and outstanding < MAX_OUTSTANDING.
  - On that edge, latch rn_addr, rn_data, rn_rw and rn_mshr_id into the mem_req_* registers.
  - read_next is asserted combinationally in that I_IDLE cycle (exactly one cycle).
- Issue FSM, I_REQ:
  - mem_req_valid=1; all mem_req_* fields are held stable until mem_req_ready=1.
  - On the accepting edge, outstanding increments and the FSM returns to I_IDLE.
  - Back-to-back throughput is 1 request per 2 cycles.
- Response FSM, R_IDLE:
  - mem_resp_ready=1 only in R_IDLE.
  - When mem_resp_valid=1, latch mem_resp_tag and mem_resp_data, then go to R_GET.
- Response FSM, R_GET (1 cycle):
  - get=1, get_tag = latched tag; capture get_* at the edge.
  - If get_valid=0: set resp_err, go to R_IDLE; no fill and no del.
  - Else if get_rw=1 (write ack): go to R_DEL.
  - Else: go to R_FILL.
- Response FSM, R_FILL:
  - fill_valid=1; fill_addr = captured get_addr; fill_data = latched response data; other fill fields from the captured get_* values.
  - Fields are held until fill_ready=1, then go to R_DEL.
- Response FSM, R_DEL (1 cycle):
  - del=1, del_tag = latched tag.
  - outstanding decrements; go to R_IDLE.
- Response-path latency: response accept → fill_valid in 2 cycles; fill accept → del in 1 cycle.
- Simultaneous increment (I_REQ accept) and decrement (R_DEL) in one cycle: outstanding is unchanged.
- outstanding never exceeds MAX_OUTSTANDING and never underflows. A decrement at 0 (impossible by protocol) holds at 0 and sets resp_err.
- The issue and response FSMs run independently; a response may arrive while a request is stalled.
- enable=0 freezes both FSMs. Pulses (read_next, get, del) are not asserted while enable=0; they are re-issued when enable returns to 1.

Optional Feature:
- Macro: MSHR_MEM_ISSUER_STATS_EN.
- Defined: adds outputs stat_req_cnt[31:0] (increments on each request accept), stat_resp_cnt[31:0] (increments on each R_DEL) and stat_stall_cnt[31:0] (increments each cycle with mem_req_valid=1 and mem_req_ready=0). All counters wrap modulo 2^32 and reset to 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single read, basic flow: rn_valid with tag 5, addr 0x01A40, rw=0, mem_req_ready=1.
  - Expect: read_next for 1 cycle; mem_req_valid with tag 5 for 1 cycle; outstanding=1.
  - Then response tag 5, data 0x3F: expect get_tag=5; fill_valid 2 cycles after the response with data 0x3F; del with tag 5; outstanding=0.
- Write ack: rn_rw=1, tag 2; response tag 2 → no fill_valid; del with tag 2 in the cycle after R_GET.
- Throttle: MAX_OUTSTANDING=4, rn_valid held high, no responses → exactly 4 requests issued and 4 read_next pulses; outstanding=4; no further read_next.
- Out-of-order completion plus simultaneous events: requests with tags 1, 2, 3; responses with tags 3, 1, 2 → fills and dels occur in order 3, 1, 2. In a cycle with both a request accept and a del, outstanding is unchanged.
- Backpressure and reset:
  - mem_req_ready=0 for 5 cycles → mem_req_* stable and a single read_next.
  - fill_ready=0 for 3 cycles → fill held, no del.
  - reset=0 mid-fill → next cycle fill_valid=0 and outstanding=0.
- Error response: response tag 6 with get_valid=0 → resp_err=1 (sticky), no fill, no del, outstanding unchanged.

Source files
------------

// File: rtl/mshr_mem_issuer.sv
// mshr_mem_issuer: drains MSHR entries into tagged memory requests and returns tagged
// responses to the cache as line fills. Define MSHR_MEM_ISSUER_STATS_EN for perf counters.
module mshr_mem_issuer #(
  parameter int addr_bits       = 20,
  parameter int data_bits       = 90,
  parameter int mshr_tag_bits   = 3,
  parameter int cpu_id_bits     = 2,
  parameter int ASSOC_BITS      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     rn_valid,
  input  logic [addr_bits-1:0]     rn_addr,
  input  logic [data_bits-1:0]     rn_data,
  input  logic                     rn_rw,
  input  logic                     rn_dirty,
  input  logic [cpu_id_bits-1:0]   rn_cpu_id,
  input  logic [mshr_tag_bits-1:0] rn_mshr_id,
  output logic                     read_next,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [addr_bits-1:0]     mem_req_addr,
  output logic [data_bits-1:0]     mem_req_data,
  output logic                     mem_req_rw,
  output logic [mshr_tag_bits-1:0] mem_req_tag,
  input  logic                     mem_resp_valid,
  output logic                     mem_resp_ready,
  input  logic [mshr_tag_bits-1:0] mem_resp_tag,
  input  logic [data_bits-1:0]     mem_resp_data,
  output logic                     get,
  output logic [mshr_tag_bits-1:0] get_tag,
  input  logic                     get_valid,
  input  logic [addr_bits-1:0]     get_addr,
  input  logic                     get_rw,
  input  logic                     get_dirty,
  input  logic [cpu_id_bits-1:0]   get_cpu_id,
  input  logic [ASSOC_BITS-1:0]    get_victim,
  output logic                     fill_valid,
  input  logic                     fill_ready,
  output logic [addr_bits-1:0]     fill_addr,
  output logic [data_bits-1:0]     fill_data,
  output logic                     fill_dirty,
  output logic [cpu_id_bits-1:0]   fill_cpu_id,
  output logic [ASSOC_BITS-1:0]    fill_victim,
  output logic                     del,
  output logic [mshr_tag_bits-1:0] del_tag,
  output logic [mshr_tag_bits:0]   outstanding,
  output logic                     resp_err
`ifdef MSHR_MEM_ISSUER_STATS_EN
  ,
  output logic [31:0]              stat_req_cnt,
  output logic [31:0]              stat_resp_cnt,
  output logic [31:0]              stat_stall_cnt
`endif
);
  localparam int OW = mshr_tag_bits + 1;
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] ONE   = OW'(1);

  typedef enum logic {I_IDLE, I_REQ} i_state_t;
  typedef enum logic [1:0] {R_IDLE, R_GET, R_FILL, R_DEL} r_state_t;

  i_state_t                 i_state;
  r_state_t                 r_state;
  logic [mshr_tag_bits-1:0] resp_tag_q;
  logic                     req_fire;
  logic                     unused_rn;

  // Fill fields come from the MSHR lookup, not the read port.
  assign unused_rn = ^{rn_dirty, rn_cpu_id};

  // Valids and pulses are masked while frozen so no handshake can complete
  // on a cycle where the FSMs are not allowed to advance.
  assign read_next      = enable && (i_state == I_IDLE) && rn_valid && (outstanding < MAX_O);
  assign mem_req_valid  = enable && (i_state == I_REQ);
  assign req_fire       = mem_req_valid && mem_req_ready;
  assign mem_resp_ready = enable && (r_state == R_IDLE);
  assign get            = enable && (r_state == R_GET);
  assign fill_valid     = enable && (r_state == R_FILL);
  assign del            = enable && (r_state == R_DEL);
  assign get_tag        = resp_tag_q;
  assign del_tag        = resp_tag_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      i_state      <= I_IDLE;
      mem_req_addr <= '0;
      mem_req_data <= '0;
      mem_req_rw   <= 1'b0;
      mem_req_tag  <= '0;
    end else if (enable) begin
      unique case (i_state)
        I_IDLE: if (read_next) begin
          mem_req_addr <= rn_addr;
          mem_req_data <= rn_data;
          mem_req_rw   <= rn_rw;
          mem_req_tag  <= rn_mshr_id;
          i_state      <= I_REQ;
        end
        I_REQ: if (mem_req_ready) i_state <= I_IDLE;
        default: i_state <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= R_IDLE;
      resp_tag_q  <= '0;
      fill_addr   <= '0;
      fill_data   <= '0;
      fill_dirty  <= 1'b0;
      fill_cpu_id <= '0;
      fill_victim <= '0;
    end else if (enable) begin
      unique case (r_state)
        R_IDLE: if (mem_resp_valid) begin
          resp_tag_q <= mem_resp_tag;
          fill_data  <= mem_resp_data;
          r_state    <= R_GET;
        end
        R_GET: begin
          fill_addr   <= get_addr;
          fill_dirty  <= get_dirty;
          fill_cpu_id <= get_cpu_id;
          fill_victim <= get_victim;
          if (!get_valid)  r_state <= R_IDLE;
          else if (get_rw) r_state <= R_DEL;
          else             r_state <= R_FILL;
        end
        R_FILL: if (fill_ready) r_state <= R_DEL;
        R_DEL:  r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Issue and retire in the same cycle cancel; a retire with nothing in
  // flight is a protocol error and must not wrap the counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding <= '0;
      resp_err    <= 1'b0;
    end else if (enable) begin
      if (req_fire && !del) begin
        outstanding <= outstanding + ONE;
      end else if (del && !req_fire) begin
        if (outstanding == '0) resp_err <= 1'b1;
        else outstanding <= outstanding - ONE;
      end
      if (get && !get_valid) resp_err <= 1'b1;
    end
  end

`ifdef MSHR_MEM_ISSUER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_req_cnt   <= '0;
      stat_resp_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (req_fire) stat_req_cnt <= stat_req_cnt + 32'd1;
      if (del) stat_resp_cnt <= stat_resp_cnt + 32'd1;
      if (mem_req_valid && !mem_req_ready) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mshr_mem_issuer.sv
// Bench for mshr_mem_issuer: an MSHR table plus a transaction/latency model checked
// every cycle at negedge, and literal expectations per directed scenario.
module tb_mshr_mem_issuer;
  localparam int AB = 20, DB = 90, TB = 3, CB = 2, VB = 2, MAXO = 4;

  logic clk = 1'b0;
  logic reset, enable;
  logic rn_valid, rn_rw, rn_dirty;
  logic [AB-1:0] rn_addr;
  logic [DB-1:0] rn_data;
  logic [CB-1:0] rn_cpu_id;
  logic [TB-1:0] rn_mshr_id;
  logic read_next, mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_data;
  logic [TB-1:0] mem_req_tag;
  logic mem_resp_valid, mem_resp_ready;
  logic [TB-1:0] mem_resp_tag;
  logic [DB-1:0] mem_resp_data;
  logic get, get_valid, get_rw, get_dirty;
  logic [TB-1:0] get_tag;
  logic [AB-1:0] get_addr;
  logic [CB-1:0] get_cpu_id;
  logic [VB-1:0] get_victim;
  logic fill_valid, fill_ready, fill_dirty;
  logic [AB-1:0] fill_addr;
  logic [DB-1:0] fill_data;
  logic [CB-1:0] fill_cpu_id;
  logic [VB-1:0] fill_victim;
  logic del, resp_err;
  logic [TB-1:0] del_tag;
  logic [TB:0] outstanding;

  always #5 clk = ~clk;

  mshr_mem_issuer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rn_valid(rn_valid), .rn_addr(rn_addr), .rn_data(rn_data), .rn_rw(rn_rw),
    .rn_dirty(rn_dirty), .rn_cpu_id(rn_cpu_id), .rn_mshr_id(rn_mshr_id), .read_next(read_next),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_rw(mem_req_rw), .mem_req_tag(mem_req_tag),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
    .get(get), .get_tag(get_tag), .get_valid(get_valid), .get_addr(get_addr), .get_rw(get_rw),
    .get_dirty(get_dirty), .get_cpu_id(get_cpu_id), .get_victim(get_victim),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_dirty(fill_dirty), .fill_cpu_id(fill_cpu_id), .fill_victim(fill_victim),
    .del(del), .del_tag(del_tag), .outstanding(outstanding), .resp_err(resp_err)
  );

  // MSHR table owned by the bench; lookups answer straight from it
  logic          e_valid [8];
  logic [AB-1:0] e_addr  [8];
  logic [DB-1:0] e_data  [8];
  logic          e_rw    [8];
  logic          e_dirty [8];
  logic [CB-1:0] e_cpu   [8];
  logic [VB-1:0] e_vic   [8];
  int rnq[$];
  int dut_del[$];

  assign get_valid  = e_valid[get_tag];
  assign get_addr   = e_addr[get_tag];
  assign get_rw     = e_rw[get_tag];
  assign get_dirty  = e_dirty[get_tag];
  assign get_cpu_id = e_cpu[get_tag];
  assign get_victim = e_vic[get_tag];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    else n_pass++;
  endtask

  task automatic drive_rn();
    if (rnq.size() > 0) begin
      rn_valid   = 1'b1;
      rn_addr    = e_addr[rnq[0]];
      rn_data    = e_data[rnq[0]];
      rn_rw      = e_rw[rnq[0]];
      rn_dirty   = e_dirty[rnq[0]];
      rn_cpu_id  = e_cpu[rnq[0]];
      rn_mshr_id = TB'(rnq[0]);
    end else begin
      rn_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; drive_rn(); #1;
  endtask

  task automatic add_entry(input int t, input logic [AB-1:0] a, input logic [DB-1:0] d,
                           input logic rw);
    e_valid[t] = 1'b1; e_addr[t] = a; e_data[t] = d; e_rw[t] = rw;
    e_dirty[t] = t[0]; e_cpu[t] = CB'(t); e_vic[t] = VB'(t + 1);
    rnq.push_back(t);
    drive_rn();
  endtask

  // Returns in the lookup cycle following the accepting edge.
  task automatic respond(input int t, input logic [DB-1:0] d);
    mem_resp_valid = 1'b1; mem_resp_tag = TB'(t); mem_resp_data = d;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic respond_wait(input int t, input logic [DB-1:0] d);
    respond(t, d);
    repeat (3) tick();
  endtask

  // Model: requests popped/in flight, and response timing by cycles since accept
  bit armed = 0, req_pend = 0, busy = 0, fill_done = 0, m_err = 0;
  int cur_tag = 0, m_out = 0, r_tag = 0, r_kind = 0, acc = 0, facc = 0, cyc = 0;
  logic [DB-1:0] r_data;
  logic exp_rn, exp_get, exp_fill, exp_del, exp_ready;

  initial forever begin
    @(negedge clk);
    exp_rn    = enable && rn_valid && !req_pend && (m_out < MAXO);
    exp_ready = enable && !busy;
    exp_get   = enable && busy && (cyc == acc + 1);
    exp_fill  = enable && busy && (r_kind == 2) && (cyc >= acc + 2) && !fill_done;
    exp_del   = enable && busy && (((r_kind == 1) && (cyc == acc + 2)) ||
                                   ((r_kind == 2) && fill_done && (cyc == facc + 1)));
    if (armed) begin
      chk("read_next", read_next, exp_rn);
      chk("mem_req_valid", mem_req_valid, enable && req_pend);
      if (req_pend) begin
        chk("mem_req_addr", mem_req_addr, e_addr[cur_tag]);
        chk("mem_req_data", mem_req_data, e_data[cur_tag]);
        chk("mem_req_rw", mem_req_rw, e_rw[cur_tag]);
        chk("mem_req_tag", mem_req_tag, cur_tag);
      end
      chk("outstanding", outstanding, m_out);
      chk("resp_err", resp_err, m_err);
      chk("mem_resp_ready", mem_resp_ready, exp_ready);
      chk("get", get, exp_get);
      if (exp_get) chk("get_tag", get_tag, r_tag);
      chk("fill_valid", fill_valid, exp_fill);
      if (exp_fill) begin
        chk("fill_addr", fill_addr, e_addr[r_tag]);
        chk("fill_data", fill_data, r_data);
        chk("fill_dirty", fill_dirty, e_dirty[r_tag]);
        chk("fill_cpu_id", fill_cpu_id, e_cpu[r_tag]);
        chk("fill_victim", fill_victim, e_vic[r_tag]);
      end
      chk("del", del, exp_del);
      if (exp_del) chk("del_tag", del_tag, r_tag);
      if (reset && del === 1'b1) dut_del.push_back(int'(del_tag));
    end
    if (!reset) begin
      armed = 1; req_pend = 0; busy = 0; fill_done = 0; m_err = 0; m_out = 0; cyc = 0;
      rnq.delete();
      for (int i = 0; i < 8; i++) e_valid[i] = 1'b0;
    end else if (enable && armed) begin
      if (req_pend && mem_req_ready) begin req_pend = 0; m_out++; end
      if (exp_rn && rnq.size() > 0) begin cur_tag = rnq.pop_front(); req_pend = 1; end
      if (exp_get && r_kind == 0) begin m_err = 1; busy = 0; end
      if (exp_fill && fill_ready) begin fill_done = 1; facc = cyc; end
      if (exp_del) begin m_out--; busy = 0; e_valid[r_tag] = 1'b0; end
      if (exp_ready && mem_resp_valid) begin
        busy = 1; fill_done = 0; acc = cyc;
        r_tag = int'(mem_resp_tag); r_data = mem_resp_data;
        r_kind = !e_valid[r_tag] ? 0 : (e_rw[r_tag] ? 1 : 2);
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, base;
    reset = 1'b0; enable = 1'b1; rn_valid = 1'b0; rn_addr = '0; rn_data = '0; rn_rw = 1'b0;
    rn_dirty = 1'b0; rn_cpu_id = '0; rn_mshr_id = '0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0; fill_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e_valid[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0; e_rw[i] = 1'b0;
      e_dirty[i] = 1'b0; e_cpu[i] = '0; e_vic[i] = '0;
    end
    repeat (3) tick();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    reset = 1'b1;
    tick();

    // single read
    add_entry(5, 20'h01A40, 90'h123, 1'b0); #1;
    chk("t1_read_next", read_next, 1);
    tick();
    chk("t1_read_next_once", read_next, 0);
    chk("t1_req_valid", mem_req_valid, 1);
    chk("t1_req_tag", mem_req_tag, 5);
    chk("t1_req_addr", mem_req_addr, 20'h01A40);
    tick();
    chk("t1_req_done", mem_req_valid, 0);
    chk("t1_out1", outstanding, 1);
    respond(5, 90'h3F);
    chk("t1_get", get, 1);
    chk("t1_get_tag", get_tag, 5);
    tick();
    chk("t1_fill_valid", fill_valid, 1);
    chk("t1_fill_data", fill_data, 90'h3F);
    chk("t1_fill_addr", fill_addr, 20'h01A40);
    tick();
    chk("t1_del", del, 1);
    chk("t1_del_tag", del_tag, 5);
    tick();
    chk("t1_out0", outstanding, 0);

    // write ack
    add_entry(2, 20'h0BEEF, 90'h55, 1'b1);
    tick(); tick();
    chk("t2_out1", outstanding, 1);
    respond(2, 90'h0);
    chk("t2_get_tag", get_tag, 2);
    tick();
    chk("t2_del", del, 1);
    chk("t2_del_tag", del_tag, 2);
    chk("t2_no_fill", fill_valid, 0);
    tick();
    chk("t2_out0", outstanding, 0);

    // throttle at MAX_OUTSTANDING
    add_entry(0, 20'h10000, 90'hA00, 1'b0);
    add_entry(1, 20'h10010, 90'hA01, 1'b0);
    add_entry(3, 20'h10030, 90'hA03, 1'b0);
    add_entry(4, 20'h10040, 90'hA04, 1'b0);
    add_entry(7, 20'h10070, 90'hA07, 1'b0); #1;
    cnt = 0;
    repeat (12) begin cnt += int'(read_next); tick(); end
    chk("t3_rn_count", cnt, 4);
    chk("t3_out4", outstanding, 4);
    chk("t3_rn_blocked", read_next, 0);
    respond_wait(0, 90'hB00);
    respond_wait(1, 90'hB01);
    respond_wait(3, 90'hB03);
    respond_wait(4, 90'hB04);
    respond_wait(7, 90'hB07);
    tick();
    chk("t3_drained", outstanding, 0);

    // out-of-order completion with a simultaneous accept and retire
    add_entry(1, 20'h20010, 90'hC01, 1'b0);
    add_entry(2, 20'h20020, 90'hC02, 1'b0);
    add_entry(3, 20'h20030, 90'hC03, 1'b0);
    repeat (8) tick();
    chk("t4_out3", outstanding, 3);
    mem_req_ready = 1'b0;
    add_entry(4, 20'h20040, 90'hC04, 1'b0);
    repeat (2) tick();
    chk("t4_stalled", mem_req_valid, 1);
    base = dut_del.size();
    respond(3, 90'h333);
    tick(); tick();
    chk("t4_del3", del, 1);
    chk("t4_sim_req", mem_req_valid, 1);
    chk("t4_out_before", outstanding, 3);
    mem_req_ready = 1'b1;
    tick();
    chk("t4_out_same", outstanding, 3);
    respond_wait(1, 90'h111);
    respond_wait(2, 90'h222);
    respond_wait(4, 90'h444);
    tick();
    chk("t4_del_count", dut_del.size() - base, 4);
    if (dut_del.size() >= base + 4) begin
      chk("t4_order0", dut_del[base], 3);
      chk("t4_order1", dut_del[base + 1], 1);
      chk("t4_order2", dut_del[base + 2], 2);
      chk("t4_order3", dut_del[base + 3], 4);
    end
    chk("t4_out0", outstanding, 0);

    // request and fill backpressure, then reset mid-fill
    mem_req_ready = 1'b0;
    add_entry(5, 20'h0C0DE, 90'h5A5A, 1'b0); #1;
    cnt = 0;
    repeat (6) begin cnt += int'(read_next); tick(); end
    chk("t5_single_rn", cnt, 1);
    chk("t5_req_held", mem_req_valid, 1);
    chk("t5_req_addr", mem_req_addr, 20'h0C0DE);
    chk("t5_req_tag", mem_req_tag, 5);
    mem_req_ready = 1'b1;
    tick();
    chk("t5_out1", outstanding, 1);
    fill_ready = 1'b0;
    respond(5, 90'h77);
    tick();
    repeat (3) begin
      chk("t5_fill_held", fill_valid, 1);
      chk("t5_no_del", del, 0);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t5_rst_fill", fill_valid, 0);
    chk("t5_rst_out", outstanding, 0);
    fill_ready = 1'b1;
    tick();

    // global stall holds the read_next pulse until released
    enable = 1'b0;
    add_entry(1, 20'h00111, 90'h11, 1'b0); #1;
    repeat (3) begin chk("t6_frozen_rn", read_next, 0); tick(); end
    enable = 1'b1; #1;
    chk("t6_rn_resume", read_next, 1);
    tick(); tick();
    chk("t6_out1", outstanding, 1);

    // response for an invalid entry
    respond(6, 90'hBAD);
    chk("t7_get_tag", get_tag, 6);
    tick();
    chk("t7_err", resp_err, 1);
    chk("t7_no_fill", fill_valid, 0);
    chk("t7_no_del", del, 0);
    tick();
    chk("t7_out_kept", outstanding, 1);
    respond_wait(1, 90'h1111);
    tick();
    chk("t7_err_sticky", resp_err, 1);
    chk("t7_out0", outstanding, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
